// File: rtl/key_input_ctrl.sv
// -----------------------------------------------------------------------------
// key_input_ctrl
//
// Turns a stream of PS/2 set-2 bytes into one-cycle game action pulses.
// A small prefix FSM (IDLE / EXT / BRK / EXT_BRK) tracks E0 and F0 prefixes.
// Each mapped key has a held bit, so keyboard typematic repeats are ignored.
// Optionally, left/right/down auto-repeat from tick_ms (DAS, then ARR).
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   : left/right/down auto-repeat; left/right is last-pressed-wins.
//   undefined : every key pulses once per make, with no repeat counters.
//
// Parameters
//   DAS_MS         delay before the first auto-repeat, in tick_ms pulses
//   ARR_MS         period between later auto-repeats, in tick_ms pulses
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   tick_ms        one-cycle 1 kHz time-base pulse
//   code           PS/2 set-2 byte
//   code_valid     one-cycle strobe qualifying code
//   enable         0 = outputs suppressed and held state cleared
//   key_*          one-cycle action pulses
//   key_drop_held  level, high while the drop key is held
// -----------------------------------------------------------------------------
module key_input_ctrl #(
    parameter int DAS_MS = 170,
    parameter int ARR_MS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic [7:0] code,
    input  logic       code_valid,
    input  logic       enable,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate_cw,
    output logic       key_rotate_ccw,
    output logic       key_drop,
    output logic       key_hold,
    output logic       key_drop_held
);

    localparam int NKEYS      = 7;
    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_DOWN   = 2;
    localparam int KEY_CW     = 3;
    localparam int KEY_CCW    = 4;
    localparam int KEY_DROP   = 5;
    localparam int KEY_HOLD   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t            state_reg, state_next;
    logic              byte_done;
    logic              is_ext, is_brk;
    logic [NKEYS-1:0]  key_hit, make_hit, break_hit, fresh_make;
    logic [NKEYS-1:0]  held_reg, held_next;
    logic [NKEYS-1:0]  pulse_reg, pulse_next;
    logic [2:0]        rpt_fire;

    // ------------------------------------------------------------------
    // Prefix FSM. E0/F0 only accumulate prefix state; any other byte
    // completes the sequence and sends the FSM back to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_done  = 1'b0;
        if (code_valid) begin
            if (code == 8'hE0) begin
                state_next = (state_reg == ST_BRK || state_reg == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
            end else if (code == 8'hF0) begin
                state_next = (state_reg == ST_EXT || state_reg == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
            end else begin
                byte_done  = 1'b1;
                state_next = ST_IDLE;
            end
        end
    end

    assign is_ext = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
    assign is_brk = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);

    // ------------------------------------------------------------------
    // Key map. Unmapped completions simply produce no hit.
    // ------------------------------------------------------------------
    always_comb begin
        key_hit = '0;
        if (byte_done) begin
            if (is_ext) begin
                case (code)
                    8'h6B:   key_hit[KEY_LEFT]  = 1'b1;
                    8'h74:   key_hit[KEY_RIGHT] = 1'b1;
                    8'h72:   key_hit[KEY_DOWN]  = 1'b1;
                    8'h75:   key_hit[KEY_CW]    = 1'b1;
                    default: key_hit = '0;
                endcase
            end else begin
                case (code)
                    8'h1A:   key_hit[KEY_CCW]  = 1'b1;
                    8'h29:   key_hit[KEY_DROP] = 1'b1;
                    8'h21:   key_hit[KEY_HOLD] = 1'b1;
                    default: key_hit = '0;
                endcase
            end
        end
    end

    assign make_hit   = key_hit & {NKEYS{~is_brk}};
    assign break_hit  = key_hit & {NKEYS{is_brk}};
    // A make only counts as a new press when the key was not already held;
    // typematic repeats from the keyboard fall out here.
    assign fresh_make = make_hit & ~held_reg;

`ifdef KEY_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat for left, right, down.
    // ------------------------------------------------------------------
    localparam int CNT_MAX_I = (DAS_MS > ARR_MS) ? DAS_MS : ARR_MS;
    localparam int CW        = (CNT_MAX_I < 2) ? 1 : $clog2(CNT_MAX_I + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CNT_MAX_I);
    localparam logic [CW-1:0] DAS_LIM = CW'(DAS_MS - 1);
    localparam logic [CW-1:0] ARR_LIM = CW'(ARR_MS - 1);

    logic       last_right_reg;
    logic [2:0] suppressed, restart;

    // Last-pressed-wins between left and right: the loser's counter is
    // frozen, and restarts from zero when the winner is released.
    assign suppressed[KEY_LEFT]  = held_reg[KEY_RIGHT] & last_right_reg;
    assign suppressed[KEY_RIGHT] = held_reg[KEY_LEFT] & ~last_right_reg;
    assign suppressed[KEY_DOWN]  = 1'b0;
    assign restart[KEY_LEFT]     = break_hit[KEY_RIGHT] & last_right_reg;
    assign restart[KEY_RIGHT]    = break_hit[KEY_LEFT] & ~last_right_reg;
    assign restart[KEY_DOWN]     = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_right_reg <= 1'b0;
        end else if (enable && fresh_make[KEY_RIGHT]) begin
            last_right_reg <= 1'b1;
        end else if (enable && fresh_make[KEY_LEFT]) begin
            last_right_reg <= 1'b0;
        end
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_rpt
        logic [CW-1:0] cnt_reg;
        logic          das_done_reg;
        logic          clear;
        logic          advance;
        logic [CW-1:0] lim;

        assign clear        = fresh_make[gi] | break_hit[gi] | restart[gi];
        assign advance      = tick_ms & held_reg[gi] & ~suppressed[gi] & ~clear;
        assign lim          = das_done_reg ? ARR_LIM : DAS_LIM;
        // This tick is the DAS-th (or ARR-th) one since the last reload.
        assign rpt_fire[gi] = advance & (cnt_reg >= lim);

        always_ff @(posedge clk) begin
            if (rst || !enable || clear) begin
                cnt_reg      <= '0;
                das_done_reg <= 1'b0;
            end else if (advance) begin
                if (rpt_fire[gi]) begin
                    cnt_reg      <= '0;
                    das_done_reg <= 1'b1;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = tick_ms ^ (DAS_MS > ARR_MS);
    assign rpt_fire   = '0;
`endif

    // ------------------------------------------------------------------
    // Held bits and action pulses. A press and a repeat expiry in the
    // same cycle merge into one pulse; a pulse is never repeated on the
    // next cycle for the same key.
    // ------------------------------------------------------------------
    always_comb begin
        held_next  = '0;
        pulse_next = '0;
        if (enable) begin
            held_next  = (held_reg | make_hit) & ~break_hit;
            pulse_next = (fresh_make | {4'b0000, rpt_fire}) & ~pulse_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_reg  <= '0;
            pulse_reg <= '0;
        end else begin
            held_reg  <= held_next;
            pulse_reg <= pulse_next;
        end
    end

    assign key_left       = pulse_reg[KEY_LEFT];
    assign key_right      = pulse_reg[KEY_RIGHT];
    assign key_down       = pulse_reg[KEY_DOWN];
    assign key_rotate_cw  = pulse_reg[KEY_CW];
    assign key_rotate_ccw = pulse_reg[KEY_CCW];
    assign key_drop       = pulse_reg[KEY_DROP];
    assign key_hold       = pulse_reg[KEY_HOLD];
    assign key_drop_held  = held_reg[KEY_DROP];

endmodule

// File: tb/tb_key_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_input_ctrl
//
// Directed bench for key_input_ctrl. A behavioural key model (per-key held
// flags and tick counts since press) predicts every output each cycle, and
// directed scenarios pin the model with hand-computed pulse counts and
// pulse times. Build with KEY_AUTOREPEAT_EN defined for both files to
// exercise auto-repeat.
// -----------------------------------------------------------------------------
module tb_key_input_ctrl;

    localparam int DAS = 170;
    localparam int ARR = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_ms = 1'b0;
    logic [7:0] code = 8'h00;
    logic       code_valid = 1'b0;
    logic       enable = 1'b1;
    logic       key_left, key_right, key_down, key_rotate_cw;
    logic       key_rotate_ccw, key_drop, key_hold, key_drop_held;

    always #5 clk = ~clk;

    key_input_ctrl #(.DAS_MS(DAS), .ARR_MS(ARR)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_ms        (tick_ms),
        .code           (code),
        .code_valid     (code_valid),
        .enable         (enable),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_down       (key_down),
        .key_rotate_cw  (key_rotate_cw),
        .key_rotate_ccw (key_rotate_ccw),
        .key_drop       (key_drop),
        .key_hold       (key_hold),
        .key_drop_held  (key_drop_held)
    );

    int checks = 0;
    int fails  = 0;
    bit run_cmp = 0;
    int tick_count = 0;
    int pcnt[7];
    int left_ticks[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_held[7];
    int         m_t[3];
    bit         m_last_right, m_ext, m_brk;
    logic [6:0] exp_pulse = '0;
    logic       exp_drop_held = 1'b0;

    function automatic int keymap(input bit ext, input logic [7:0] b);
        if (ext) begin
            case (b)
                8'h6B: return 0;
                8'h74: return 1;
                8'h72: return 2;
                8'h75: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h1A: return 4;
            8'h29: return 5;
            8'h21: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic bit due(input int t);
        return (t == DAS) || (t > DAS && ((t - DAS) % ARR) == 0);
    endfunction

    task automatic model_step();
        logic [6:0] p;
        logic [2:0] skip;
        int k;
        bit brk;
        p = '0; skip = '0; k = -1; brk = 0;
        if (rst) begin
            for (int i = 0; i < 7; i++) m_held[i] = 0;
            for (int i = 0; i < 3; i++) m_t[i] = 0;
            m_last_right = 0; m_ext = 0; m_brk = 0;
            exp_pulse = '0; exp_drop_held = 1'b0;
            return;
        end
        if (code_valid) begin
            if (code == 8'hE0) m_ext = 1;
            else if (code == 8'hF0) m_brk = 1;
            else begin
                k = keymap(m_ext, code); brk = m_brk; m_ext = 0; m_brk = 0;
            end
        end
        if (!enable) begin
            for (int i = 0; i < 7; i++) m_held[i] = 0;
            for (int i = 0; i < 3; i++) m_t[i] = 0;
        end else begin
            if (k >= 0 && !brk && !m_held[k]) begin
                m_held[k] = 1; p[k] = 1'b1;
                if (k < 3) begin m_t[k] = 0; skip[k] = 1'b1; end
                if (k == 0) m_last_right = 0;
                if (k == 1) m_last_right = 1;
            end else if (k >= 0 && brk) begin
                m_held[k] = 0;
                if (k < 3) m_t[k] = 0;
                if (k == 1 && m_last_right) begin m_t[0] = 0; skip[0] = 1'b1; end
                if (k == 0 && !m_last_right) begin m_t[1] = 0; skip[1] = 1'b1; end
            end
`ifdef KEY_AUTOREPEAT_EN
            if (tick_ms) begin
                for (int j = 0; j < 3; j++) begin
                    bit frozen;
                    frozen = (j == 0 && m_held[1] && m_last_right) ||
                             (j == 1 && m_held[0] && !m_last_right);
                    if (m_held[j] && !skip[j] && !frozen) begin
                        m_t[j]++;
                        if (due(m_t[j])) p[j] = 1'b1;
                    end
                end
            end
`endif
        end
        exp_pulse     = enable ? p : 7'b0;
        exp_drop_held = m_held[5];
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare and pulse monitor ----------------
    initial forever begin
        logic [7:0] got, exp;
        @(negedge clk);
        if (run_cmp) begin
            got = {key_drop_held, key_hold, key_drop, key_rotate_ccw,
                   key_rotate_cw, key_down, key_right, key_left};
            exp = {exp_drop_held, exp_pulse};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL cycle_compare t=%0t: got %b, expected %b", $time, got, exp);
            end
            if (key_left)       begin pcnt[0]++; left_ticks.push_back(tick_count); end
            if (key_right)      pcnt[1]++;
            if (key_down)       pcnt[2]++;
            if (key_rotate_cw)  pcnt[3]++;
            if (key_rotate_ccw) pcnt[4]++;
            if (key_drop)       pcnt[5]++;
            if (key_hold)       pcnt[6]++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        code = b; code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0; code = 8'h00;
        $display("tx byte=%02h enable=%0b t=%0t", b, enable, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            tick_ms = 1'b1; tick_count++;
            @(posedge clk); #1;
            tick_ms = 1'b0;
            @(posedge clk);
            @(posedge clk);
        end
        #1;
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < 7; i++) s += pcnt[i];
        return s;
    endfunction

    initial begin
        int b0, b1, s0;
        for (int i = 0; i < 7; i++) pcnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        run_cmp = 1;
        rst = 1'b0;

        // reset state
        check("reset_pulses", int'({key_left, key_right, key_down, key_rotate_cw,
                                    key_rotate_ccw, key_drop, key_hold}), 0);
        check("reset_drop_held", int'(key_drop_held), 0);

        // E0 6B -> one left pulse, one cycle after the 6B strobe
        s0 = total_pulses();
        send(8'hE0);
        send(8'h6B);
        check("left_pulse_cycle", int'(key_left), 1);
        check("left_others_zero", int'({key_right, key_down, key_rotate_cw,
                                        key_rotate_ccw, key_drop, key_hold}), 0);
        idle(1);
        check("left_pulse_width", int'(key_left), 0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        idle(2);
        check("left_single_total", total_pulses() - s0, 1);

        // drop make, typematic repeats, break
        b0 = pcnt[5];
        send(8'h29);
        check("drop_pulse", int'(key_drop), 1);
        check("drop_held_on_pulse", int'(key_drop_held), 1);
        repeat (5) send(8'h29);
        send(8'hF0);
        check("drop_held_before_break", int'(key_drop_held), 1);
        send(8'h29);
        check("drop_held_after_break", int'(key_drop_held), 0);
        idle(2);
        check("drop_pulse_count", pcnt[5] - b0, 1);

        // left held for 300 ticks
        tick_count = 0;
        left_ticks.delete();
        send(8'hE0); send(8'h6B);
        idle(2);
        ticks(300);
`ifdef KEY_AUTOREPEAT_EN
        check("das_pulse_count", left_ticks.size(), 4);
        if (left_ticks.size() == 4) begin
            check("das_tick_make", left_ticks[0], 0);
            check("das_tick_first", left_ticks[1], 170);
            check("das_tick_arr1", left_ticks[2], 220);
            check("das_tick_arr2", left_ticks[3], 270);
        end
`else
        check("norpt_pulse_count", left_ticks.size(), 1);
`endif
        send(8'hE0); send(8'hF0); send(8'h6B);
        idle(2);

        // left held, right pressed later; right wins, left restarts afterwards
        b0 = pcnt[0];
        send(8'hE0); send(8'h6B);
        ticks(100);
        b1 = pcnt[1];
        send(8'hE0); send(8'h74);
        ticks(250);
`ifdef KEY_AUTOREPEAT_EN
        check("lr_right_repeats", pcnt[1] - b1, 3);
`else
        check("lr_right_repeats", pcnt[1] - b1, 1);
`endif
        check("lr_left_frozen", pcnt[0] - b0, 1);
        send(8'hE0); send(8'hF0); send(8'h74);
        b0 = pcnt[0];
        ticks(169);
        check("lr_left_restart_early", pcnt[0] - b0, 0);
        ticks(1);
`ifdef KEY_AUTOREPEAT_EN
        check("lr_left_restart_das", pcnt[0] - b0, 1);
`else
        check("lr_left_restart_das", pcnt[0] - b0, 0);
`endif
        send(8'hE0); send(8'hF0); send(8'h6B);
        idle(2);

        // reset mid-sequence aborts the E0 prefix
        send(8'hE0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        s0 = total_pulses();
        send(8'h6B);
        idle(3);
        check("rst_abort_no_pulse", total_pulses() - s0, 0);
        send(8'h1A);
        check("rst_abort_idle_decode", int'(key_rotate_ccw), 1);
        send(8'hF0); send(8'h1A);
        idle(2);

        // enable low while a 1A make arrives
        b0 = pcnt[4];
        enable = 1'b0;
        send(8'h1A);
        idle(2);
        check("disabled_no_ccw", pcnt[4] - b0, 0);
        enable = 1'b1;
        idle(1);
        send(8'h1A);
        idle(1);
        check("disabled_held_clear", pcnt[4] - b0, 1);
        send(8'hF0); send(8'h1A);

        // enable drop clears a held key; other mapped keys
        b0 = pcnt[2];
        send(8'hE0); send(8'h72);
        enable = 1'b0; idle(1); enable = 1'b1;
        send(8'hE0); send(8'h72);
        idle(2);
        check("down_repress_after_disable", pcnt[2] - b0, 2);
        send(8'hE0); send(8'hF0); send(8'h72);
        b0 = pcnt[3]; b1 = pcnt[6];
        send(8'hE0); send(8'h75);
        send(8'h21);
        send(8'h21);
        idle(2);
        check("rotate_cw_count", pcnt[3] - b0, 1);
        check("hold_count", pcnt[6] - b1, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h21);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
